pixel_batch_writer: RTL and testbench
=====================================

// Module: pixel_batch_writer
// PURPOSE
// Consumer/sequencer for pixel_processor. Pulses new_frame to start a frame and
// start_next_batch to advance to each later batch. Captures each NUM_PIXELS-wide
// result and drains it, one pixel per accepted cycle and in raster order, into a
// framebuffer write port with ready/valid backpressure.
// PARAMETERS
// NUM_PIXELS     8    pixels per batch; must divide SCREEN_WIDTH
// PIXEL_WIDTH    12   bits per pixel (4:4:4 RGB)
// SCREEN_WIDTH   640  pixels per line
// SCREEN_HEIGHT  480  lines per frame
// ADDR_WIDTH     19   framebuffer word address width; >= clog2(W*H)
// PORTS
// clk               in   1      clock; all logic on rising edge
// reset             in   1      asynchronous, active-high reset
// frame_start       in   1      one-cycle request to render a frame; honoured only when busy==0
// new_frame         out  1      one-cycle pulse to processor: restart at (0,0), bump frame number
// start_next_batch  out  1      one-cycle pulse to processor: compute next batch
// result            in   NUM_PIXELS*PIXEL_WIDTH  batch; pixel k at [k*PW +: PW], k=0 leftmost
// result_ready      in   1      processor batch complete; held until next pulse
// fb_wr_en          out  1      framebuffer write valid
// fb_wr_addr        out  ADDR_WIDTH  linear address y*SCREEN_WIDTH+x
// fb_wr_data        out  PIXEL_WIDTH pixel data
// fb_wr_ready       in   1      framebuffer accepts write when fb_wr_en&&fb_wr_ready at clk edge
// busy              out  1      frame in progress (state != IDLE or drain nonempty)
// frame_done        out  1      one-cycle pulse after last pixel of frame accepted
// BEHAVIOUR
// - Reset, async: state=IDLE; all outputs 0; counters, drain count and address=0.
// - FSM states:
//   IDLE:  frame_start -> ISSUE_F; fb_wr_addr<=0; batch_x<=0; batch_y<=0.
//   ISSUE_F: new_frame=1 for exactly 1 cycle -> WAIT.
//   WAIT:  result_ready is sampled only here. result_ready is stale in the pulse
//          cycle and goes low one cycle later; WAIT begins after that cycle.
//          Capture when result_ready && drain_cnt==0 (or drain finishing this cycle):
//          load shift reg, drain_cnt<=NUM_PIXELS.
//          Capture of the last batch (batch_x==W-N && batch_y==H-1) -> FLUSH.
//          Capture of any other batch: start_next_batch=1 in the same cycle; stay in WAIT.
//          Counters advance with start_next_batch: batch_x+=N. At W-N: batch_x<=0, batch_y+=1.
//   FLUSH: no pulses. When the final write handshake completes -> IDLE.
//          frame_done=1 on the following cycle.
// - Processor overlap: start_next_batch is issued at capture, so the next batch
//   computes while the current one drains. With fb_wr_ready=1, drain (N cycles)
//   ends before the next result_ready and throughput equals processor rate.
//   Under backpressure, capture stalls; result_ready stays high and the processor holds.
// - Drain: fb_wr_en=(drain_cnt!=0). fb_wr_data=pixel 0 of shift reg.
//   On handshake: shift right by PW, drain_cnt-=1, fb_wr_addr+=1.
//   fb_wr_addr and fb_wr_data stay stable while fb_wr_en && !fb_wr_ready.
// - Pulses: new_frame and start_next_batch are never asserted together.
//   Each is never asserted in two consecutive cycles.
// - frame_start while busy: ignored, not queued.
// - Final address written = W*H-1; the address counter never wraps within a frame.
// - Reset mid-frame: everything returns to IDLE immediately; a pending write is dropped.
//   Processor is resynchronised by the next new_frame.
// TESTING
// 1. Reset, then frame_start (W=16,H=2,N=8) with model processor (result_ready 16 cycles
//    after a pulse) -> new_frame once, start_next_batch x3, 32 writes at addr 0..31, frame_done once.
// 2. Batch with pixel k = 12'h100+k -> data 100..107 in order at consecutive addresses.
// 3. Hold fb_wr_ready=0 for 20 cycles mid-drain -> addr/data stable, no capture,
//    no start_next_batch until drain empties.
// 4. result_ready held high from power-up, then frame_start -> no capture until result_ready
//    has gone low and then high again after new_frame.
// 5. frame_start pulsed while busy -> ignored: exactly one new_frame, busy drops after frame_done.
// 6. Assert reset during batch 2 -> all outputs 0 next cycle; new frame restarts at addr 0.

Source files
------------

// File: rtl/pixel_batch_writer_if.sv
// Processor sequencing pulses, batch result and framebuffer write port of pixel_batch_writer.
// Latency: none; this interface only bundles wires.
// Backpressure: fb_wr_ready from the framebuffer side; result_ready is held by the processor until the next pulse.
interface pixel_batch_writer_if #(
  parameter int NUM_PIXELS  = 8,
  parameter int PIXEL_WIDTH = 12,
  parameter int ADDR_WIDTH  = 19
);
  logic                              new_frame;
  logic                              start_next_batch;
  logic [NUM_PIXELS*PIXEL_WIDTH-1:0] result;
  logic                              result_ready;
  logic                              fb_wr_en;
  logic [ADDR_WIDTH-1:0]             fb_wr_addr;
  logic [PIXEL_WIDTH-1:0]            fb_wr_data;
  logic                              fb_wr_ready;

  // Writer side: drives the processor pulses and the framebuffer write request.
  modport master (
    output new_frame, start_next_batch, fb_wr_en, fb_wr_addr, fb_wr_data,
    input  result, result_ready, fb_wr_ready
  );

  // Environment side: processor results and framebuffer acceptance.
  modport slave (
    input  new_frame, start_next_batch, fb_wr_en, fb_wr_addr, fb_wr_data,
    output result, result_ready, fb_wr_ready
  );
endinterface

// File: rtl/pixel_batch_writer.sv
// Sequences pixel_processor batches for one frame and drains each batch, raster order, to the framebuffer.
// Latency: first write one cycle after a batch is captured; then one pixel per accepted cycle.
// Backpressure: fb_wr_ready low freezes addr/data and blocks the next capture; the processor holds result_ready.
module pixel_batch_writer #(
  parameter int NUM_PIXELS    = 8,
  parameter int PIXEL_WIDTH   = 12,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int ADDR_WIDTH    = 19
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  output logic                 busy,
  output logic                 frame_done,
  pixel_batch_writer_if.master bus
);
  localparam int BW = NUM_PIXELS * PIXEL_WIDTH;
  localparam int XW = (SCREEN_WIDTH > 1) ? $clog2(SCREEN_WIDTH) : 1;
  localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
  localparam int CW = $clog2(NUM_PIXELS + 1);
  localparam logic [XW-1:0] LAST_X   = XW'(SCREEN_WIDTH - NUM_PIXELS);
  localparam logic [YW-1:0] LAST_Y   = YW'(SCREEN_HEIGHT - 1);
  localparam logic [XW-1:0] STEP_X   = XW'(NUM_PIXELS);
  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_PIXELS);

  typedef enum logic [1:0] {IDLE, ISSUE_F, WAIT, FLUSH} state_t;
  state_t state, state_n;

  logic [BW-1:0]         shift_reg;
  logic [CW-1:0]         drain_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [XW-1:0]         batch_x;
  logic [YW-1:0]         batch_y;
  logic                  wr_fire, drain_last, drain_free, last_batch, frame_go;
  logic                  capture, new_frame_c, next_batch_c;

  assign wr_fire    = (drain_cnt != '0) && bus.fb_wr_ready;
  assign drain_last = wr_fire && (drain_cnt == CW'(1));
  // A batch may be loaded once the drain is empty or empties on this very edge.
  assign drain_free = (drain_cnt == '0) || drain_last;
  assign last_batch = (batch_x == LAST_X) && (batch_y == LAST_Y);
  assign frame_go   = (state == IDLE) && frame_start;

  assign bus.new_frame        = new_frame_c;
  assign bus.start_next_batch = next_batch_c;
  assign bus.fb_wr_en         = (drain_cnt != '0);
  assign bus.fb_wr_addr       = wr_addr;
  assign bus.fb_wr_data       = shift_reg[PIXEL_WIDTH-1:0];
  assign busy                 = (state != IDLE) || (drain_cnt != '0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and pulses. result_ready is only looked at in WAIT, which always
  // starts the cycle after a pulse, so the stale level from the previous batch is never seen.
  always_comb begin
    state_n      = state;
    capture      = 1'b0;
    new_frame_c  = 1'b0;
    next_batch_c = 1'b0;
    case (state)
      IDLE:    if (frame_start) state_n = ISSUE_F;
      ISSUE_F: begin
        new_frame_c = 1'b1;
        state_n     = WAIT;
      end
      WAIT: begin
        if (bus.result_ready && drain_free) begin
          capture = 1'b1;
          if (last_batch) state_n = FLUSH;
          else            next_batch_c = 1'b1;
        end
      end
      FLUSH:   if (drain_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Drain path: capture loads the batch, each accepted write shifts out pixel 0 and bumps the address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      drain_cnt <= '0;
      wr_addr   <= '0;
    end else begin
      if (capture) begin
        shift_reg <= bus.result;
        drain_cnt <= FULL_CNT;
      end else if (wr_fire) begin
        shift_reg <= shift_reg >> PIXEL_WIDTH;
        drain_cnt <= drain_cnt - CW'(1);
      end
      if (frame_go)     wr_addr <= '0;
      else if (wr_fire) wr_addr <= wr_addr + ADDR_WIDTH'(1);
    end
  end

  // Position of the batch being awaited; advances together with start_next_batch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      batch_x <= '0;
      batch_y <= '0;
    end else if (frame_go) begin
      batch_x <= '0;
      batch_y <= '0;
    end else if (next_batch_c) begin
      if (batch_x == LAST_X) begin
        batch_x <= '0;
        batch_y <= batch_y + YW'(1);
      end else begin
        batch_x <= batch_x + STEP_X;
      end
    end
  end

  // frame_done pulses the cycle after the last pixel of the frame is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_done <= 1'b0;
    else       frame_done <= (state == FLUSH) && drain_last;
  end
endmodule

// File: tb/tb_pixel_batch_writer.sv
// Directed bench for pixel_batch_writer on a 16x2 screen with 8-pixel batches.
// A model processor raises result_ready 16 cycles after each pulse and holds it until the next one.
// Batch b of a frame carries pixel k = 12'h100*(b+1)+k, so address a must receive 12'h100*(a/8+1)+a%8.
module tb_pixel_batch_writer;
  localparam int N = 8, PW = 12, W = 16, H = 2, AW = 19, PIXELS = W * H;

  logic clk = 1'b0, reset = 1'b1, frame_start = 1'b0;
  logic busy, frame_done;
  int   total = 0, bad = 0;

  pixel_batch_writer_if #(.NUM_PIXELS(N), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

  pixel_batch_writer #(
    .NUM_PIXELS(N), .PIXEL_WIDTH(PW), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .busy(busy), .frame_done(frame_done), .bus(bus)
  );

  always #5 clk = ~clk;

  // Model processor; result_ready is high from power-up.
  logic          proc_rdy = 1'b1;
  int            pbatch = 0, pcnt = 0;
  logic [N*PW-1:0] proc_res;
  always @(posedge clk) begin
    if (bus.new_frame) begin
      pbatch <= 0; pcnt <= 16; proc_rdy <= 1'b0;
    end else if (bus.start_next_batch) begin
      pbatch <= pbatch + 1; pcnt <= 16; proc_rdy <= 1'b0;
    end else if (pcnt != 0) begin
      pcnt <= pcnt - 1;
      if (pcnt == 1) proc_rdy <= 1'b1;
    end
  end
  always_comb begin
    proc_res = '0;
    for (int k = 0; k < N; k++) proc_res[k*PW +: PW] = 12'(12'h100 * (pbatch + 1) + k);
  end
  assign bus.result       = proc_res;
  assign bus.result_ready = proc_rdy;

  // Monitor, sampled mid-cycle: pulse counts, pulse rule violations, accepted writes.
  int cyc = 0, nf_cnt = 0, snb_cnt = 0, fd_cnt = 0, viol_cnt = 0, nf_cyc = 0, first_lat = -1;
  bit prev_nf = 1'b0, prev_snb = 1'b0, first_seen = 1'b1;
  int log_addr[$];
  int log_data[$];
  always @(negedge clk) begin
    cyc++;
    if (bus.new_frame) begin nf_cnt++; nf_cyc = cyc; first_seen = 1'b0; end
    if (bus.start_next_batch) snb_cnt++;
    if (frame_done) fd_cnt++;
    if ((bus.new_frame && bus.start_next_batch) || (bus.new_frame && prev_nf) ||
        (bus.start_next_batch && prev_snb)) viol_cnt++;
    prev_nf  = bus.new_frame;
    prev_snb = bus.start_next_batch;
    if (bus.fb_wr_en && !first_seen) begin first_lat = cyc - nf_cyc; first_seen = 1'b1; end
    if (bus.fb_wr_en && bus.fb_wr_ready && !reset) begin
      log_addr.push_back(int'(bus.fb_wr_addr));
      log_data.push_back(int'(bus.fb_wr_data));
    end
  end

  function automatic int exp_pix(input int a);
    return 'h100 * (a / N + 1) + (a % N);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    tick(); frame_start = 1'b1;
    tick(); frame_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_start = 1'b0; bus.fb_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.new_frame !== 1'b0) begin bad++; $display("FAIL reset_new_frame got=%0b want=0", bus.new_frame); end
    total++; if (bus.start_next_batch !== 1'b0) begin bad++; $display("FAIL reset_start_next_batch got=%0b want=0", bus.start_next_batch); end
    total++; if (bus.fb_wr_en !== 1'b0) begin bad++; $display("FAIL reset_fb_wr_en got=%0b want=0", bus.fb_wr_en); end
    total++; if (bus.fb_wr_addr !== '0) begin bad++; $display("FAIL reset_fb_wr_addr got=%0h want=0", bus.fb_wr_addr); end
    total++; if (bus.fb_wr_data !== '0) begin bad++; $display("FAIL reset_fb_wr_data got=%0h want=0", bus.fb_wr_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%0b want=0", frame_done); end
    tick(); reset = 1'b0;
    repeat (5) tick();
    total++; if (nf_cnt !== 0 || busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset new_frames=%0d busy=%0b want 0 and 0", nf_cnt, busy); end
  endtask

  // result_ready has been high since power-up; the first capture must wait for the fresh rise.
  task automatic test_stale_ready();
    bit ok;
    int base;
    base = log_addr.size();
    pulse_start();
    wait_done(400, ok);
    repeat (3) tick();
    total++; if (!ok) begin bad++; $display("FAIL stale_frame_done got=timeout want=pulse"); end
    total++; if (first_lat !== 18) begin bad++; $display("FAIL stale_first_write_latency got=%0d want=18", first_lat); end
    total++; if (log_data.size() <= base || log_data[base] !== 'h100) begin
      bad++; $display("FAIL stale_first_data got=%0h want=100", (log_data.size() > base) ? log_data[base] : -1);
    end
  endtask

  task automatic test_full_frame();
    bit ok;
    int base, nf0, snb0, fd0, v0, n_a, n_d, fa, fd_i;
    base = log_addr.size(); nf0 = nf_cnt; snb0 = snb_cnt; fd0 = fd_cnt; v0 = viol_cnt;
    pulse_start();
    wait_done(400, ok);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL frame_busy_at_done got=%0b want=0", busy); end
    repeat (5) tick();
    total++; if (!ok) begin bad++; $display("FAIL frame_done_seen got=timeout want=pulse"); end
    total++; if (nf_cnt - nf0 !== 1) begin bad++; $display("FAIL frame_new_frame_count got=%0d want=1", nf_cnt - nf0); end
    total++; if (snb_cnt - snb0 !== 3) begin bad++; $display("FAIL frame_next_batch_count got=%0d want=3", snb_cnt - snb0); end
    total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL frame_done_count got=%0d want=1", fd_cnt - fd0); end
    total++; if (viol_cnt - v0 !== 0) begin bad++; $display("FAIL frame_pulse_rules violations=%0d want=0", viol_cnt - v0); end
    total++; if (log_addr.size() - base !== PIXELS) begin bad++; $display("FAIL frame_write_count got=%0d want=%0d", log_addr.size() - base, PIXELS); end
    n_a = 0; n_d = 0; fa = -1; fd_i = -1;
    for (int i = 0; i < PIXELS; i++) begin
      if (base + i >= log_addr.size() || log_addr[base+i] != i) begin n_a++; if (fa < 0) fa = i; end
      if (base + i >= log_data.size() || log_data[base+i] != exp_pix(i)) begin n_d++; if (fd_i < 0) fd_i = i; end
    end
    total++; if (n_a != 0) begin bad++; $display("FAIL frame_addr_seq mismatches=%0d first_at=%0d want=0", n_a, fa); end
    total++; if (n_d != 0) begin bad++; $display("FAIL frame_data_seq mismatches=%0d first_at=%0d want=0", n_d, fd_i); end
  endtask

  task automatic test_batch_data();
    bit ok;
    int base;
    base = log_addr.size();
    pulse_start();
    wait_done(400, ok);
    repeat (3) tick();
    total++; if (!ok) begin bad++; $display("FAIL batch_frame_done got=timeout want=pulse"); end
    for (int k = 0; k < N; k++) begin
      total++;
      if (log_data.size() <= base + k || log_data[base+k] !== 'h100 + k || log_addr[base+k] !== k) begin
        bad++;
        $display("FAIL batch_pixel_%0d got addr=%0d data=%0h want addr=%0d data=%0h", k,
                 (log_addr.size() > base + k) ? log_addr[base+k] : -1,
                 (log_data.size() > base + k) ? log_data[base+k] : -1, k, 'h100 + k);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int base, snb0, changed, n_err;
    logic [AW-1:0] hold_a;
    logic [PW-1:0] hold_d;
    base = log_addr.size(); snb0 = snb_cnt;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (log_addr.size() - base >= 3) begin ok = 1'b1; break; end
    end
    bus.fb_wr_ready = 1'b0;
    @(negedge clk);
    hold_a = bus.fb_wr_addr; hold_d = bus.fb_wr_data;
    total++; if (!ok) begin bad++; $display("FAIL bp_reach_mid_drain got=timeout want=3 writes"); end
    total++; if (hold_a !== AW'(3) || hold_d !== 12'h103) begin bad++; $display("FAIL bp_stall_word got addr=%0d data=%0h want addr=3 data=103", hold_a, hold_d); end
    changed = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (bus.fb_wr_addr !== hold_a || bus.fb_wr_data !== hold_d || bus.fb_wr_en !== 1'b1) changed++;
    end
    tick();
    total++; if (changed != 0) begin bad++; $display("FAIL bp_stable cycles_changed=%0d want=0", changed); end
    total++; if (snb_cnt - snb0 !== 1) begin bad++; $display("FAIL bp_no_capture next_batch_pulses=%0d want=1", snb_cnt - snb0); end
    bus.fb_wr_ready = 1'b1;
    wait_done(400, ok);
    repeat (3) tick();
    total++; if (!ok) begin bad++; $display("FAIL bp_frame_done got=timeout want=pulse"); end
    n_err = 0;
    for (int i = 0; i < PIXELS; i++)
      if (base + i >= log_addr.size() || log_addr[base+i] != i || log_data[base+i] != exp_pix(i)) n_err++;
    total++; if (n_err != 0 || log_addr.size() - base != PIXELS) begin
      bad++; $display("FAIL bp_frame_writes mismatches=%0d count=%0d want 0 and %0d", n_err, log_addr.size() - base, PIXELS);
    end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    int nf0, fd0;
    nf0 = nf_cnt; fd0 = fd_cnt;
    pulse_start();
    repeat (5) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_in_frame got=%0b want=1", busy); end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (30) tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    wait_done(400, ok);
    total++; if (!ok || busy !== 1'b0) begin bad++; $display("FAIL busy_drop done_seen=%0b busy=%0b want 1 and 0", ok, busy); end
    repeat (40) tick();
    total++; if (nf_cnt - nf0 !== 1) begin bad++; $display("FAIL busy_ignore new_frames=%0d want=1", nf_cnt - nf0); end
    total++; if (fd_cnt - fd0 !== 1 || busy !== 1'b0) begin bad++; $display("FAIL busy_no_queue frame_dones=%0d busy=%0b want 1 and 0", fd_cnt - fd0, busy); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base, n_err;
    base = log_addr.size();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (log_addr.size() - base >= 10) begin ok = 1'b1; break; end
    end
    reset = 1'b1;
    @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL rst_mid_reach_batch2 got=timeout want=10 writes"); end
    total++; if (bus.new_frame !== 1'b0 || bus.start_next_batch !== 1'b0 || frame_done !== 1'b0) begin
      bad++; $display("FAIL rst_mid_pulses got nf=%0b snb=%0b fd=%0b want 0 0 0", bus.new_frame, bus.start_next_batch, frame_done);
    end
    total++; if (bus.fb_wr_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_en_busy got en=%0b busy=%0b want 0 0", bus.fb_wr_en, busy); end
    total++; if (bus.fb_wr_addr !== '0 || bus.fb_wr_data !== '0) begin bad++; $display("FAIL rst_mid_addr_data got addr=%0d data=%0h want 0 0", bus.fb_wr_addr, bus.fb_wr_data); end
    tick(); reset = 1'b0;
    repeat (3) tick();
    base = log_addr.size();
    pulse_start();
    wait_done(400, ok);
    repeat (3) tick();
    total++; if (!ok) begin bad++; $display("FAIL rst_restart_done got=timeout want=pulse"); end
    total++; if (log_addr.size() <= base || log_addr[base] !== 0) begin
      bad++; $display("FAIL rst_restart_first_addr got=%0d want=0", (log_addr.size() > base) ? log_addr[base] : -1);
    end
    n_err = 0;
    for (int i = 0; i < PIXELS; i++)
      if (base + i >= log_addr.size() || log_addr[base+i] != i || log_data[base+i] != exp_pix(i)) n_err++;
    total++; if (n_err != 0 || log_addr.size() - base != PIXELS) begin
      bad++; $display("FAIL rst_restart_writes mismatches=%0d count=%0d want 0 and %0d", n_err, log_addr.size() - base, PIXELS);
    end
  endtask

  initial begin
    bus.fb_wr_ready = 1'b1;
    test_reset();
    test_stale_ready();
    test_full_frame();
    test_batch_data();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
